// File: rtl/dmem_arbiter_pkg.sv
// Shared data-memory types and the dmem_arbiter FSM state encoding.
package dmem_arbiter_pkg;

   typedef logic [31:0] word;

   localparam logic MEM_READ_EN  = 1'b0;
   localparam logic MEM_WRITE_EN = 1'b1;

   typedef struct packed {
      logic mem_enable;
      logic mem_en;
      word  address;
      word  data_in;
   } data_memory_interface_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } dmem_arb_state_t;

endpackage

// File: rtl/dmem_arb_select.sv
// Winner selection for dmem_arbiter: fixed priority to requester 0, or round robin when
// DMEM_ARB_ROUND_ROBIN_EN is defined; either way requester 1 is forced in after MAX_WAIT losses.
module dmem_arb_select #(
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       arb_en,
   input  logic [1:0] req_valid,
   output logic [1:0] grant
);

   localparam int unsigned  WW       = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
   localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

   logic [WW-1:0] wait_q, wait_d;
   logic          starved;

   assign starved = (wait_q == WAIT_MAX);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   logic ptr_q, ptr_d;  // requester favoured at the next contention

   always_comb begin
      grant = 2'b00;
      if (req_valid == 2'b11) grant = (starved || ptr_q) ? 2'b10 : 2'b01;
      else                    grant = req_valid;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (arb_en && (|req_valid)) ptr_d = ~grant[1];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) ptr_q <= 1'b0;
      else          ptr_q <= ptr_d;
   end
`else
   always_comb begin
      grant = 2'b00;
      if (req_valid == 2'b11) grant = starved ? 2'b10 : 2'b01;
      else                    grant = req_valid;
   end
`endif

   always_comb begin
      wait_d = wait_q;
      if (arb_en && req_valid[1]) begin
         if (grant[1])      wait_d = '0;
         else if (!starved) wait_d = wait_q + 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) wait_q <= '0;
      else          wait_q <= wait_d;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: accept, access, respond (one access per three cycles).
// Optional macro DMEM_ARB_ROUND_ROBIN_EN selects round-robin contention instead of fixed priority.
//
// state   | meaning
// IDLE    | waiting; grants one valid requester combinationally and latches its fields
// ACCESS  | drives data memory from the latched request (suppressed when out of range)
// RESPOND | one-cycle response strobe to the winner
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_LIMIT = 1024,
   parameter int unsigned MAX_WAIT   = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_write,
   input  word  [1:0]             req_addr,
   input  word  [1:0]             req_wdata,
   output logic [1:0]             rsp_valid,
   output logic                   rsp_err,
   output word                    rsp_rdata,
   output data_memory_interface_t mem_sig,
   input  word                    mem_rdata
);

   dmem_arb_state_t state_q, state_d;
   logic [1:0]      grant;
   logic [1:0]      win_q, win_d;
   logic            wr_q, wr_d;
   word             addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
   logic            idle, accept, sel, oor;

   assign idle   = (state_q == IDLE);
   assign accept = idle && (|req_valid);
   assign sel    = grant[1];
   assign oor    = (addr_q >= word'(ADDR_LIMIT));

   dmem_arb_select #(.MAX_WAIT(MAX_WAIT)) u_select (
      .clock     (clock),
      .reset_n   (reset_n),
      .arb_en    (idle),
      .req_valid (req_valid),
      .grant     (grant)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req_valid) state_d = ACCESS;
         ACCESS:  state_d = RESPOND;
         RESPOND: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      win_d   = win_q;
      wr_d    = wr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (accept) begin
         win_d   = grant;
         wr_d    = req_write[sel];
         addr_d  = req_addr[sel];
         wdata_d = req_wdata[sel];
      end
      if (state_q == ACCESS) rdata_d = mem_rdata;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         win_q   <= '0;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         win_q   <= win_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // reset_n gates req_ready because reset parks the FSM in IDLE, where grant is live
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      rsp_err   = 1'b0;
      rsp_rdata = '0;
      mem_sig   = '0;
      case (state_q)
         IDLE: if (reset_n) req_ready = grant;
         ACCESS: begin
            if (!oor) begin
               mem_sig.mem_enable = 1'b1;
               mem_sig.mem_en     = wr_q ? MEM_WRITE_EN : MEM_READ_EN;
               mem_sig.address    = addr_q;
               mem_sig.data_in    = wdata_q;
            end
         end
         RESPOND: begin
            rsp_valid = win_q;
            rsp_err   = oor;
            rsp_rdata = (oor || wr_q) ? '0 : rdata_q;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int unsigned ADDR_LIMIT = 1024;
   localparam int unsigned MAX_WAIT   = 4;

   logic                   clock = 1'b0;
   logic                   reset_n = 1'b0;
   logic [1:0]             req_valid, req_ready, req_write, rsp_valid;
   word  [1:0]             req_addr, req_wdata;
   logic                   rsp_err;
   word                    rsp_rdata, mem_rdata;
   data_memory_interface_t mem_sig;

   word        mem [256];
   word        ref_mem [256];
   logic       bd_we = 1'b0;
   logic [7:0] bd_idx = '0;
   word        bd_dat = '0;
   int         n_vec = 0;
   int         n_err = 0;

   dmem_arbiter #(.ADDR_LIMIT(ADDR_LIMIT), .MAX_WAIT(MAX_WAIT)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_write (req_write),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_err   (rsp_err),
      .rsp_rdata (rsp_rdata),
      .mem_sig   (mem_sig),
      .mem_rdata (mem_rdata)
   );

   always #5 clock = ~clock;

   // Environment data memory: word array, combinational read, write on the clock edge
   always @(posedge clock) begin
      if (bd_we) mem[bd_idx] <= bd_dat;
      else if (mem_sig.mem_enable && mem_sig.mem_en == MEM_WRITE_EN)
         mem[mem_sig.address[9:2]] <= mem_sig.data_in;
   end
   assign mem_rdata = mem[mem_sig.address[9:2]];

   task automatic idle_inputs();
      req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
   endtask

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic apply_reset();
      @(negedge clock);
      reset_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      step();
   endtask

   task automatic backdoor(input logic [7:0] idx, input word dat);
      bd_we = 1'b1; bd_idx = idx; bd_dat = dat;
      step();
      bd_we = 1'b0;
   endtask

   task automatic test_reset();
      req_valid = 2'b11; req_addr[0] = 32'h10; req_addr[1] = 32'h20;
      #3;
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready got=%b exp=00", req_ready); end
      n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
      n_vec++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
      n_vec++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
      n_vec++; if (mem_sig.mem_enable !== 1'b0) begin n_err++; $display("FAIL reset_mem_enable got=%b exp=0", mem_sig.mem_enable); end
      idle_inputs();
      @(negedge clock);
      reset_n = 1'b1;
      step();
   endtask

   task automatic test_single_load();
      backdoor(8'd4, 32'hDEADBEEF);
      req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 32'h10;
      @(negedge clock);
      n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL load_ready got=%b exp=01", req_ready); end
      step();
      idle_inputs();
      @(negedge clock);
      n_vec++; if (mem_sig.mem_enable !== 1'b1) begin n_err++; $display("FAIL load_mem_enable got=%b exp=1", mem_sig.mem_enable); end
      n_vec++; if (mem_sig.mem_en !== MEM_READ_EN || mem_sig.address !== 32'h10) begin n_err++; $display("FAIL load_mem_ctl got en=%b addr=%h exp en=0 addr=10", mem_sig.mem_en, mem_sig.address); end
      n_vec++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL load_ready_access got=%b exp=00", req_ready); end
      step();
      @(negedge clock);
      n_vec++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL load_rsp_valid got=%b exp=01", rsp_valid); end
      n_vec++; if (rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0) begin n_err++; $display("FAIL load_rsp_data got=%h err=%b exp=deadbeef err=0", rsp_rdata, rsp_err); end
      step();
      @(negedge clock);
      n_vec++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL load_rsp_one_cycle got=%b exp=00", rsp_valid); end
      step();
   endtask

   task automatic test_store_load();
      req_valid = 2'b10; req_write = 2'b10; req_addr[1] = 32'h20; req_wdata[1] = 32'h12345678;
      @(negedge clock);
      n_vec++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL store_ready got=%b exp=10", req_ready); end
      step();
      idle_inputs();
      @(negedge clock);
      n_vec++; if (mem_sig.mem_enable !== 1'b1 || mem_sig.mem_en !== MEM_WRITE_EN || mem_sig.data_in !== 32'h12345678) begin n_err++; $display("FAIL store_mem_ctl got en=%b we=%b d=%h exp 1 1 12345678", mem_sig.mem_enable, mem_sig.mem_en, mem_sig.data_in); end
      step();
      @(negedge clock);
      n_vec++; if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL store_rsp got v=%b err=%b d=%h exp 10 0 0", rsp_valid, rsp_err, rsp_rdata); end
      step();
      req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 32'h20;
      @(negedge clock);
      n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL reload_ready got=%b exp=01", req_ready); end
      step();
      idle_inputs();
      step();
      @(negedge clock);
      n_vec++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h12345678) begin n_err++; $display("FAIL reload_rsp got v=%b err=%b d=%h exp 01 0 12345678", rsp_valid, rsp_err, rsp_rdata); end
      step();
   endtask

   task automatic test_out_of_range();
      req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 32'h400;
      @(negedge clock);
      n_vec++; if (req_ready !== 2'b01 || mem_sig.mem_enable !== 1'b0) begin n_err++; $display("FAIL oor_accept got ready=%b en=%b exp 01 0", req_ready, mem_sig.mem_enable); end
      step();
      idle_inputs();
      @(negedge clock);
      n_vec++; if (mem_sig.mem_enable !== 1'b0) begin n_err++; $display("FAIL oor_mem_enable got=%b exp=0", mem_sig.mem_enable); end
      step();
      @(negedge clock);
      n_vec++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0 || mem_sig.mem_enable !== 1'b0) begin n_err++; $display("FAIL oor_rsp got v=%b err=%b d=%h en=%b exp 01 1 0 0", rsp_valid, rsp_err, rsp_rdata, mem_sig.mem_enable); end
      step();
   endtask

   task automatic test_contention();
      logic [1:0] exp_g;
      apply_reset();
      req_valid = 2'b11; req_write = 2'b00; req_addr[0] = 32'h30; req_addr[1] = 32'h34;
      for (int g = 0; g < 10; g++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         exp_g = (g % 2 == 1) ? 2'b10 : 2'b01;
`else
         exp_g = (g % 5 == 4) ? 2'b10 : 2'b01;
`endif
         @(negedge clock);
         n_vec++; if (req_ready !== exp_g) begin n_err++; $display("FAIL contention_grant%0d got=%b exp=%b", g, req_ready, exp_g); end
         step();
         step();
         @(negedge clock);
         n_vec++; if (rsp_valid !== exp_g) begin n_err++; $display("FAIL contention_rsp%0d got=%b exp=%b", g, rsp_valid, exp_g); end
         step();
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_access();
      apply_reset();
      backdoor(8'd16, 32'h11111111);
      req_valid = 2'b01; req_write = 2'b01; req_addr[0] = 32'h40; req_wdata[0] = 32'hCAFEF00D;
      @(negedge clock);
      n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rst_store_ready got=%b exp=01", req_ready); end
      step();
      @(negedge clock);
      #1;
      reset_n = 1'b0;
      #1;
      n_vec++; if (mem_sig.mem_enable !== 1'b0 || req_ready !== 2'b00) begin n_err++; $display("FAIL rst_mid_ctl got en=%b ready=%b exp 0 00", mem_sig.mem_enable, req_ready); end
      n_vec++; if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_mid_rsp got v=%b err=%b d=%h exp 00 0 0", rsp_valid, rsp_err, rsp_rdata); end
      idle_inputs();
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      n_vec++; if (mem[16] !== 32'h11111111) begin n_err++; $display("FAIL rst_mem_unchanged got=%h exp=11111111", mem[16]); end
      step();
      req_valid = 2'b01; req_write = 2'b00; req_addr[0] = 32'h40;
      @(negedge clock);
      n_vec++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL rst_after_ready got=%b exp=01", req_ready); end
      step();
      idle_inputs();
      step();
      @(negedge clock);
      n_vec++; if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_rdata !== 32'h11111111) begin n_err++; $display("FAIL rst_after_rsp got v=%b err=%b d=%h exp 01 0 11111111", rsp_valid, rsp_err, rsp_rdata); end
      step();
   endtask

   // Transaction-level model: pending requests per requester, a loss count for
   // requester 1 and the last winner; memory effect tracked in ref_mem.
   task automatic test_random();
      logic [1:0] pv;
      logic       pw [2];
      word        pa [2];
      word        pd [2];
      int         mdl_wait, mdl_last, ewin;
      logic [1:0] exp_ready;
      logic       exp_oor;
      word        exp_rdata;
      logic [7:0] idx;
      apply_reset();
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = $urandom;
         backdoor(8'(i), ref_mem[i]);
      end
      pv = 2'b00; mdl_wait = 0; mdl_last = 1;
      for (int i = 0; i < 2; i++) begin pw[i] = 1'b0; pa[i] = '0; pd[i] = '0; end
      for (int t = 0; t < 150; t++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pv[i] && $urandom_range(0, 2) != 0) begin
               pv[i] = 1'b1;
               pw[i] = 1'($urandom_range(0, 1));
               pa[i] = ($urandom_range(0, 7) == 0) ? (32'h400 + ($urandom_range(0, 255) << 2))
                                                   : word'($urandom_range(0, 255) << 2);
               pd[i] = $urandom;
            end
         end
         req_valid = pv;
         req_write = {pw[1], pw[0]};
         req_addr[0] = pa[0]; req_addr[1] = pa[1];
         req_wdata[0] = pd[0]; req_wdata[1] = pd[1];
         if (pv == 2'b00)                      ewin = -1;
         else if (pv == 2'b01)                 ewin = 0;
         else if (pv == 2'b10)                 ewin = 1;
         else if (mdl_wait >= int'(MAX_WAIT)) ewin = 1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         else                                  ewin = 1 - mdl_last;
`else
         else                                  ewin = 0;
`endif
         exp_ready = (ewin < 0) ? 2'b00 : ((ewin == 0) ? 2'b01 : 2'b10);
         @(negedge clock);
         n_vec++; if (req_ready !== exp_ready) begin n_err++; $display("FAIL rand%0d_ready got=%b exp=%b", t, req_ready, exp_ready); end
         if (ewin < 0) begin
            step();
            continue;
         end
         if (pv[1] && ewin == 0 && mdl_wait < int'(MAX_WAIT)) mdl_wait++;
         if (ewin == 1) mdl_wait = 0;
         mdl_last = ewin;
         exp_oor = (pa[ewin] >= ADDR_LIMIT);
         idx = pa[ewin][9:2];
         exp_rdata = (exp_oor || pw[ewin]) ? 32'h0 : ref_mem[idx];
         if (!exp_oor && pw[ewin]) ref_mem[idx] = pd[ewin];
         pv[ewin] = 1'b0;
         step();
         req_valid = 2'($urandom); req_addr[0] = $urandom; req_addr[1] = $urandom;
         @(negedge clock);
         n_vec++; if (mem_sig.mem_enable !== !exp_oor || req_ready !== 2'b00) begin n_err++; $display("FAIL rand%0d_access got en=%b ready=%b exp en=%b ready=00", t, mem_sig.mem_enable, req_ready, !exp_oor); end
         if (!exp_oor) begin
            n_vec++; if (mem_sig.address !== pa[ewin] || mem_sig.mem_en !== pw[ewin]) begin n_err++; $display("FAIL rand%0d_mem_ctl got addr=%h we=%b exp addr=%h we=%b", t, mem_sig.address, mem_sig.mem_en, pa[ewin], pw[ewin]); end
         end
         step();
         req_valid = 2'($urandom);
         @(negedge clock);
         n_vec++; if (rsp_valid !== exp_ready || rsp_err !== exp_oor || rsp_rdata !== exp_rdata) begin n_err++; $display("FAIL rand%0d_rsp got v=%b err=%b d=%h exp v=%b err=%b d=%h", t, rsp_valid, rsp_err, rsp_rdata, exp_ready, exp_oor, exp_rdata); end
         step();
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      test_reset();
      test_single_load();
      test_store_load();
      test_out_of_range();
      test_contention();
      test_reset_mid_access();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_LIMIT, default 1024, meaning the first byte address outside data memory.
REQ-002 SHALL have parameter MAX_WAIT, default 4, meaning the number of consecutive lost arbitrations after which a waiting requester is forced to win.
REQ-003 SHALL have port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 2, meaning request valid (bit 0 = core LSU, bit 1 = program loader).
REQ-006 SHALL have port req_ready, output, 2, meaning request accepted this cycle.
REQ-007 SHALL have port req_write, input, 2, meaning 1 = store, 0 = load, per requester.
REQ-008 SHALL have port req_addr, input, 2 x word, meaning per-requester byte address.
REQ-009 SHALL have port req_wdata, input, 2 x word, meaning per-requester store data.
REQ-010 SHALL have port rsp_valid, output, 2, meaning one-cycle response strobe to the owning requester.
REQ-011 SHALL have port rsp_err, output, 1, meaning the response is an out-of-range error; qualified by rsp_valid.
REQ-012 SHALL have port rsp_rdata, output, word, meaning load data; qualified by rsp_valid.
REQ-013 SHALL have port mem_sig, output, data_memory_interface_t, meaning the data-memory control bundle.
REQ-014 SHALL have port mem_rdata, input, word, meaning combinational read data from data memory.

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESPOND.
- IDLE -> ACCESS when any req_valid bit is set; otherwise stay in IDLE.
- ACCESS -> RESPOND unconditionally.
- RESPOND -> IDLE unconditionally.
REQ-016 In IDLE with any req_valid set, SHALL select one winner and assert req_ready for that bit only, combinationally in the same cycle; it SHALL latch the winner's write, addr and wdata.
REQ-017 req_ready SHALL be 0 in ACCESS and RESPOND.
REQ-018 In ACCESS, SHALL drive mem_sig from the latched fields:
- mem_enable = 1;
- mem_en = MEM_WRITE_EN or MEM_READ_EN;
- address and data_in from the latched values.
In all other states, mem_enable SHALL be 0.
REQ-019 A store SHALL commit at the rising edge ending ACCESS; a load SHALL register mem_rdata at that same edge.
REQ-020 In RESPOND, SHALL assert rsp_valid for the winner only, for exactly one cycle; there is no backpressure. Latency is fixed: accept in cycle T, memory access in T+1, rsp_valid in T+2. Peak throughput is one access per 3 cycles.
REQ-021 If the latched address >= ADDR_LIMIT:
- mem_enable SHALL stay 0 in ACCESS;
- in RESPOND, rsp_err = 1 and rsp_rdata = 0.
Otherwise rsp_err = 0.
REQ-022 Store responses SHALL carry rsp_rdata = 0.
REQ-023 SHALL keep a wait counter (width $clog2(MAX_WAIT+1)) for requester 1.
- Increment, saturating, each time requester 1 is valid in IDLE and loses.
- Clear when requester 1 wins.
- When the counter equals MAX_WAIT, requester 1 SHALL win the next arbitration.
REQ-024 req_valid changes outside IDLE SHALL be ignored; a requester holds its request until req_ready.

Reset
REQ-025 Asserting reset_n low at any time SHALL immediately force:
- state IDLE;
- req_ready = 0, rsp_valid = 0, rsp_err = 0, rsp_rdata = 0;
- mem_enable = 0;
- wait counter = 0 and round-robin pointer = 0.
An in-flight access SHALL be discarded and SHALL NOT write memory.

Configuration
REQ-026 With DMEM_ARB_ROUND_ROBIN_EN defined, contention SHALL grant the requester that did not win last (pointer reset favours requester 0); the REQ-023 counter is still present.
REQ-027 Without DMEM_ARB_ROUND_ROBIN_EN, requester 0 SHALL have fixed priority, subject only to REQ-023.

Structure
REQ-028 word, data_memory_interface_t, MEM_READ_EN and MEM_WRITE_EN SHALL come from the shared params package; the FSM state enum SHALL be added there as dmem_arb_state_t.
REQ-029 Winner selection SHALL be a sub-module dmem_arb_select containing the priority / round-robin logic and the wait counter; the FSM and datapath latches stay in dmem_arbiter.

Verification
REQ-030 The bench SHALL cover these directed scenarios:
- Single load: req_valid=01, addr=0x10, memory holds 0xDEADBEEF -> req_ready=01 same cycle; mem_enable=1 in T+1; rsp_valid=01 with rdata 0xDEADBEEF in T+2.
- Store then load: requester 1 writes 0x12345678 to 0x20, then requester 0 reads 0x20 -> read returns 0x12345678; rsp_err=0 for both.
- Out of range: addr=0x400 with ADDR_LIMIT=1024 -> mem_enable never 1; rsp_err=1; rdata=0.
- Contention: both valid continuously, without the macro -> requester 1 wins on exactly every 5th grant (MAX_WAIT=4). With the macro -> grants alternate 0,1,0,1.
- Reset mid-access: a store is accepted, reset_n falls during ACCESS before the edge -> memory is unchanged, all outputs are 0, and the next request works normally.
